// File: rtl/ssd_scan_driver_if.sv
// Core-side display bus of the seven-segment scan driver.
// The core stages content with a load pulse; the driver returns its pin-level outputs.
interface ssd_scan_driver_if;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  blank_in;
  logic [3:0]  blink_in;
  logic [3:0]  dp_in;
  logic        pending;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output load, digits_in, blank_in, blink_in, dp_in,
    input  pending, an, seg, dp
  );

  modport slave (
    input  load, digits_in, blank_in, blink_in, dp_in,
    output pending, an, seg, dp
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver: anode scan, hex decode,
// per-digit blank/blink/dp, with staged content committed only at frame boundaries.
module ssd_scan_driver #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic             clk,
  input  logic             rst,
  ssd_scan_driver_if.slave bus
);

  localparam int unsigned NDIG  = 4;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  typedef struct packed {
    logic [NDIG-1:0][DIG_W-1:0] digits;
    logic [NDIG-1:0]            blank;
    logic [NDIG-1:0]            blink;
    logic [NDIG-1:0]            dp;
  } disp_t;

  localparam disp_t DISP_RST = '{digits: '0, blank: '1, blink: '0, dp: '0};

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [DIG_W-1:0] h);
    logic [SEG_W-1:0] s;
    s = 7'h7F;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  digit_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [FRM_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic               pending_q, pending_d;
  disp_t              stage_q, stage_d;
  disp_t              active_q, active_d;
  logic [NDIG-1:0]    an_q, an_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               dp_q, dp_d;

  logic               div_wrap;
  logic               frame_end;
  logic [1:0]         idx;
  logic               lit;

  // Digit scan state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIG0;
    else     state_q <= state_d;
  end

  // Scan sequencer: advance one digit each time the divider wraps.
  always_comb begin
    state_d = state_q;
    if (div_wrap) begin
      case (state_q)
        DIG0:    state_d = DIG1;
        DIG1:    state_d = DIG2;
        DIG2:    state_d = DIG3;
        DIG3:    state_d = DIG0;
        default: state_d = DIG0;
      endcase
    end
  end

  // Timing, staging/commit and output pattern.
  always_comb begin
    div_cnt_d     = div_cnt_q + DIV_W'(1);
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    pending_d     = pending_q;
    stage_d       = stage_q;
    active_d      = active_q;

    div_wrap  = (div_cnt_q == DIV_LAST);
    frame_end = div_wrap && (state_q == DIG3);

    if (div_wrap) div_cnt_d = '0;

    if (frame_end) begin
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FRM_W'(1);
      end
    end

    // Commit uses the staging contents from before any same-cycle load.
    if (frame_end && pending_q) begin
      active_d  = stage_q;
      pending_d = 1'b0;
    end

    if (bus.load) begin
      stage_d.digits = bus.digits_in;
      stage_d.blank  = bus.blank_in;
      stage_d.blink  = bus.blink_in;
      stage_d.dp     = bus.dp_in;
      pending_d      = 1'b1;
    end

    idx = 2'(state_q);
    lit = !active_q.blank[idx] && !(active_q.blink[idx] && blink_phase_q);

    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = hex_to_seg(active_q.digits[idx]);
      dp_d  = ~active_q.dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pending_q     <= 1'b0;
      stage_q       <= DISP_RST;
      active_q      <= DISP_RST;
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
    end else begin
      div_cnt_q     <= div_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      pending_q     <= pending_d;
      stage_q       <= stage_d;
      active_q      <= active_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign bus.pending = pending_q;
  assign bus.an      = an_q;
  assign bus.seg     = seg_q;
  assign bus.dp      = dp_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: a cycle-indexed display model predicts
// each output beat, which is queued at drive time and compared after the edge.
module tb_ssd_scan_driver;

  localparam int unsigned CLK_DIV      = 4;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int unsigned FRAME        = 4 * CLK_DIV;

  typedef struct packed {
    logic [31:0] fr;
    logic [15:0] d;
    logic [3:0]  bl;
    logic [3:0]  bk;
    logic [3:0]  dp;
  } ent_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ssd_scan_driver_if bus ();

  ssd_scan_driver #(
    .CLK_DIV      (CLK_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  int unsigned n = 0;
  ent_t        act;
  ent_t        pq [$];
  out_t        sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  function automatic ent_t reset_content();
    ent_t e;
    e    = '0;
    e.bl = 4'hF;
    return e;
  endfunction

  // One clock: drive inputs, predict the output beat, then compare after the edge.
  task automatic step(input logic do_load, input logic [15:0] d, input logic [3:0] bl,
                      input logic [3:0] bk, input logic [3:0] dpi, input logic do_rst);
    out_t        o;
    out_t        got;
    ent_t        e;
    int unsigned idx;
    logic        phase;
    logic        pend;
    logic [3:0]  nib;

    rst           = do_rst;
    bus.load      = do_load;
    bus.digits_in = do_load ? d   : 16'($urandom);
    bus.blank_in  = do_load ? bl  : 4'($urandom);
    bus.blink_in  = do_load ? bk  : 4'($urandom);
    bus.dp_in     = do_load ? dpi : 4'($urandom);

    while (pq.size() > 0 && pq[0].fr <= n / FRAME) act = pq.pop_front();

    o.an  = 4'hF;
    o.seg = 7'h7F;
    o.dp  = 1'b1;
    if (!do_rst) begin
      idx   = (n / CLK_DIV) % 4;
      phase = 1'(((n / FRAME) / BLINK_FRAMES) % 2);
      if (!act.bl[idx] && !(act.bk[idx] && phase)) begin
        o.an    = 4'hF;
        o.an[idx] = 1'b0;
        nib     = act.d[idx*4 +: 4];
        o.seg   = SEG_LUT[nib];
        o.dp    = ~act.dp[idx];
      end
    end
    sb.push_back(o);

    @(posedge clk);
    #1;
    bus.load = 1'b0;

    if (do_rst) begin
      n   = 0;
      act = reset_content();
      pq.delete();
    end else begin
      if (do_load) begin
        e.fr = (n + 1) / FRAME + 1;
        e.d  = d;
        e.bl = bl;
        e.bk = bk;
        e.dp = dpi;
        if (pq.size() > 0 && pq[pq.size()-1].fr == e.fr) void'(pq.pop_back());
        pq.push_back(e);
      end
      n++;
    end

    pend = 1'b0;
    foreach (pq[i]) if (pq[i].fr * FRAME > n) pend = 1'b1;

    got.an  = bus.an;
    got.seg = bus.seg;
    got.dp  = bus.dp;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      o = sb.pop_front();
      chk("an",  32'(got.an),  32'(o.an));
      chk("seg", 32'(got.seg), 32'(o.seg));
      chk("dp",  32'(got.dp),  32'(o.dp));
    end
    chk("pending", 32'(bus.pending), 32'(pend));
    chk("an_single_low", 32'($countones(~got.an) <= 1), 32'd1);
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic idle_until(input int unsigned phase);
    for (int i = 0; i < int'(FRAME) && (n % FRAME) != phase; i++) idle();
  endtask

  initial begin
    act           = reset_content();
    bus.load      = 1'b0;
    bus.digits_in = '0;
    bus.blank_in  = '0;
    bus.blink_in  = '0;
    bus.dp_in     = '0;

    // Reset, then nothing loaded: display stays dark.
    repeat (3) step(1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    repeat (40) idle();

    // Basic content with decimal point on digit 0.
    step(1'b1, 16'h1234, 4'h0, 4'h0, 4'b0001, 1'b0);
    repeat (60) idle();

    // Two loads inside one frame: only the last is ever shown.
    idle_until(2);
    step(1'b1, 16'hAAAA, 4'h0, 4'h0, 4'h0, 1'b0);
    idle();
    step(1'b1, 16'h5555, 4'h0, 4'h0, 4'h0, 1'b0);
    repeat (50) idle();

    // Load on the frame_end cycle: commits one frame later.
    idle_until(FRAME - 1);
    step(1'b1, 16'h9876, 4'h0, 4'h0, 4'b1000, 1'b0);
    repeat (50) idle();

    // Load just before and on a frame_end: both values get a frame each.
    idle_until(FRAME - 2);
    step(1'b1, 16'hC0DE, 4'b0100, 4'h0, 4'h0, 1'b0);
    step(1'b1, 16'hBEEF, 4'h0, 4'h0, 4'b0110, 1'b0);
    repeat (40) idle();

    // Blink on digit 1 across several blink periods.
    step(1'b1, 16'h8F0E, 4'h0, 4'b0010, 4'h0, 1'b0);
    repeat (12 * FRAME) idle();

    // Reset together with a load, mid-frame: load is dropped.
    idle_until(6);
    step(1'b1, 16'hFFFF, 4'h0, 4'h0, 4'hF, 1'b1);
    repeat (40) idle();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
